// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage.
// Issues word loads/stores over a req/ack handshake, holds the EX/MEM
// stage (stall) while an access is outstanding, and registers MEM/WB.
// Optional feature macro: MEM_TIMEOUT_EN aborts an access that has not
// been acknowledged within TIMEOUT_CYCLES cycles of waiting.
// A misaligned access or an aborted access writes back a bubble whose
// wb_data is 0 and raises mem_err for one cycle.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter bit ALIGN_CHECK    = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  ctrl_mem,
  input  logic [31:0] rd_mem,
  input  logic [31:0] alu_result,
  input  logic [31:0] write_data1,
  input  logic [31:0] pc4_mem,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [2:0]  ctrl_wb,
  output logic [31:0] rd_wb,
  output logic [31:0] wb_data,
  output logic        mem_err
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_access;
  logic        w_misaligned;
  logic        w_req;
  logic        w_stall;
  logic        w_abort;
  logic        w_mis_err;
  logic        w_err;
  logic        w_timeout;
  logic [31:0] w_sel_data;
  logic [2:0]  r_ctrl_wb;
  logic [31:0] r_rd_wb;
  logic [31:0] r_wb_data;
  logic        r_mem_err;

  // Both read and write set is treated as a write (dmem_we follows mem_write).
  assign w_access     = ctrl_mem[4] | ctrl_mem[3];
  assign w_misaligned = ALIGN_CHECK & w_access & (alu_result[1:0] != 2'b00);
  assign w_err        = w_mis_err | w_abort;

  // Memory-side outputs; req and stall are held low throughout reset.
  assign dmem_req   = reset_n & w_req;
  assign stall      = reset_n & w_stall;
  assign dmem_we    = ctrl_mem[3];
  assign dmem_addr  = alu_result;
  assign dmem_wdata = write_data1;

  assign ctrl_wb = r_ctrl_wb;
  assign rd_wb   = r_rd_wb;
  assign wb_data = r_wb_data;
  assign mem_err = r_mem_err;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] r_wait_cnt;

  assign w_timeout = (r_wait_cnt == CNT_LAST);

  // Count WAIT cycles; the count is zero on every entry into WAIT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wait_cnt <= {CNT_W{1'b0}};
    end else if (r_state == ST_IDLE) begin
      r_wait_cnt <= {CNT_W{1'b0}};
    end else if (r_wait_cnt != CNT_LAST) begin
      r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end else begin
      r_wait_cnt <= r_wait_cnt;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state, handshake request, stall and error conditions.
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_stall     = 1'b0;
    w_abort     = 1'b0;
    w_mis_err   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_misaligned) begin
          w_mis_err   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_access) begin
          w_req = 1'b1;
          if (dmem_ack) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_stall     = 1'b1;
            w_state_nxt = ST_WAIT;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (dmem_ack) begin
          w_req       = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_timeout) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_req       = 1'b1;
          w_stall     = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Write-back source select (00/11 ALU, 01 load data, 10 PC+4).
  always_comb begin
    w_sel_data = alu_result;
    case (ctrl_mem[1:0])
      2'b01:   w_sel_data = dmem_rdata;
      2'b10:   w_sel_data = pc4_mem;
      default: w_sel_data = alu_result;
    endcase
  end

  // MEM/WB register: bubble (reg_write cleared, rest held) while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ctrl_wb <= 3'b000;
      r_rd_wb   <= 32'h0000_0000;
      r_wb_data <= 32'h0000_0000;
      r_mem_err <= 1'b0;
    end else if (w_stall) begin
      r_ctrl_wb <= {1'b0, r_ctrl_wb[1:0]};
      r_rd_wb   <= r_rd_wb;
      r_wb_data <= r_wb_data;
      r_mem_err <= 1'b0;
    end else begin
      r_ctrl_wb <= {ctrl_mem[2] & ~w_err, ctrl_mem[1:0]};
      r_rd_wb   <= rd_mem;
      r_wb_data <= w_err ? 32'h0000_0000 : w_sel_data;
      r_mem_err <= w_err;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vectors, a transaction-level
// model checked every cycle, and hand-computed literal expectations.
module tb_mem_stage;

  localparam int TMO = 4;
`ifdef MEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic [4:0]  ctrl_mem;
  logic [31:0] rd_mem;
  logic [31:0] alu_result;
  logic [31:0] write_data1;
  logic [31:0] pc4_mem;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic [2:0]  ctrl_wb;
  logic [31:0] rd_wb;
  logic [31:0] wb_data;
  logic        mem_err;

  int n_vec = 0;
  int n_err = 0;

  mem_stage #(.TIMEOUT_CYCLES(TMO), .ALIGN_CHECK(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .ctrl_mem(ctrl_mem), .rd_mem(rd_mem),
    .alu_result(alu_result), .write_data1(write_data1), .pc4_mem(pc4_mem),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .ctrl_wb(ctrl_wb), .rd_wb(rd_wb), .wb_data(wb_data),
    .mem_err(mem_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Model: an instruction occupies the stage for 'age' cycles until it leaves
  // (stall low). Outputs are derived from the instruction rules only.
  initial begin : model
    logic [2:0]  e_ctrl;
    logic [31:0] e_rd;
    logic [31:0] e_data;
    logic        e_err;
    int          age;
    logic        acc, mis, abrt, req_e, stall_e;
    logic [31:0] sel;
    e_ctrl = 3'b000; e_rd = 32'h0; e_data = 32'h0; e_err = 1'b0; age = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        e_ctrl = 3'b000; e_rd = 32'h0; e_data = 32'h0; e_err = 1'b0; age = 0;
      end
      chk("m_ctrl_wb", 32'(ctrl_wb), 32'(e_ctrl));
      chk("m_rd_wb", rd_wb, e_rd);
      chk("m_wb_data", wb_data, e_data);
      chk("m_mem_err", 32'(mem_err), 32'(e_err));
      acc   = ctrl_mem[4] | ctrl_mem[3];
      mis   = acc && (alu_result[1:0] != 2'b00);
      abrt  = TO_EN && acc && !mis && (age == TMO) && !dmem_ack;
      req_e = reset_n && acc && !mis && !abrt;
      stall_e = req_e && !dmem_ack;
      chk("m_req", 32'(dmem_req), 32'(req_e));
      chk("m_stall", 32'(stall), 32'(stall_e));
      chk("m_we", 32'(dmem_we), 32'(ctrl_mem[3]));
      chk("m_addr", dmem_addr, alu_result);
      chk("m_wdata", dmem_wdata, write_data1);
      if (ctrl_mem[1:0] == 2'd1)      sel = dmem_rdata;
      else if (ctrl_mem[1:0] == 2'd2) sel = pc4_mem;
      else                            sel = alu_result;
      if (reset_n) begin
        if (stall_e) begin
          e_ctrl[2] = 1'b0;
          e_err = 1'b0;
          age = age + 1;
        end else begin
          e_ctrl = {ctrl_mem[2] && !mis && !abrt, ctrl_mem[1:0]};
          e_rd   = rd_mem;
          e_data = (mis || abrt) ? 32'h0 : sel;
          e_err  = mis || abrt;
          age = 0;
        end
      end
    end
  end

  // One cycle of stimulus; returns at the following negedge for sampling.
  task automatic step(input logic rst, input logic [4:0] c, input logic [31:0] rd,
                      input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc4,
                      input logic ack, input logic [31:0] rdata);
    @(posedge clk);
    #1;
    reset_n = rst; ctrl_mem = c; rd_mem = rd; alu_result = alu;
    write_data1 = wd; pc4_mem = pc4; dmem_ack = ack; dmem_rdata = rdata;
    @(negedge clk);
  endtask

  initial begin : stim
    int nst;
    reset_n = 1'b0; ctrl_mem = 5'b00000; rd_mem = 32'h0; alu_result = 32'h0;
    write_data1 = 32'h0; pc4_mem = 32'h0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    step(1'b0, 5'b00000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    chk("rst_ctrl_wb", 32'(ctrl_wb), 32'h0);
    chk("rst_req", 32'(dmem_req), 32'h0);
    step(1'b0, 5'b00000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);

    // ALU op then PC+4 op
    step(1'b1, 5'b00100, 32'd5, 32'h11, 32'h0, 32'h104, 1'b0, 32'h0);
    chk("alu_req", 32'(dmem_req), 32'h0);
    chk("alu_stall", 32'(stall), 32'h0);
    step(1'b1, 5'b00110, 32'd6, 32'h55, 32'h0, 32'h44, 1'b0, 32'h0);
    chk("alu_ctrl_wb", 32'(ctrl_wb), 32'h4);
    chk("alu_wb_data", wb_data, 32'h11);
    chk("alu_rd_wb", rd_wb, 32'd5);

    // Load acked after 3 wait cycles
    nst = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 5'b10101, 32'd7, 32'h100, 32'h0, 32'h108, 1'b0, 32'h0);
      nst += int'(stall);
      if (i == 0) chk("pc4_wb_data", wb_data, 32'h44);
      if (i == 1) chk("load_bubble", 32'(ctrl_wb[2]), 32'h0);
      chk("load_we", 32'(dmem_we), 32'h0);
    end
    step(1'b1, 5'b10101, 32'd7, 32'h100, 32'h0, 32'h108, 1'b1, 32'hDEAD_BEEF);
    nst += int'(stall);
    chk("load_stall_cycles", 32'(nst), 32'd3);

    // Store acked in the same cycle
    step(1'b1, 5'b01000, 32'd0, 32'h204, 32'h1234_5678, 32'h0, 1'b1, 32'h0);
    chk("load_wb_data", wb_data, 32'hDEAD_BEEF);
    chk("load_ctrl_wb", 32'(ctrl_wb), 32'h5);
    chk("store_req", 32'(dmem_req), 32'h1);
    chk("store_we", 32'(dmem_we), 32'h1);
    chk("store_stall", 32'(stall), 32'h0);

    // Misaligned load
    step(1'b1, 5'b10101, 32'd9, 32'h103, 32'h0, 32'h0, 1'b0, 32'h0);
    chk("store_ctrl_wb", 32'(ctrl_wb), 32'h0);
    chk("mis_req", 32'(dmem_req), 32'h0);

    // ALU op with a stray ack
    step(1'b1, 5'b00100, 32'd10, 32'hA, 32'h0, 32'h0, 1'b1, 32'hBAD0_BAD0);
    chk("mis_err", 32'(mem_err), 32'h1);
    chk("mis_reg_write", 32'(ctrl_wb[2]), 32'h0);

    // Read and write both set: a write, no error
    step(1'b1, 5'b11101, 32'd11, 32'h208, 32'hCAFE_F00D, 32'h0, 1'b1, 32'h0BAD_F00D);
    chk("mis_err_clear", 32'(mem_err), 32'h0);
    chk("stray_wb_data", wb_data, 32'hA);
    chk("both_we", 32'(dmem_we), 32'h1);

    // Reset while a load waits
    step(1'b1, 5'b10101, 32'd12, 32'h300, 32'h0, 32'h0, 1'b0, 32'h0);
    chk("both_wb_data", wb_data, 32'h0BAD_F00D);
    chk("both_err", 32'(mem_err), 32'h0);
    step(1'b1, 5'b10101, 32'd12, 32'h300, 32'h0, 32'h0, 1'b0, 32'h0);
    chk("wait_stall", 32'(stall), 32'h1);
    step(1'b0, 5'b00000, 32'd0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    chk("rstw_req", 32'(dmem_req), 32'h0);
    chk("rstw_stall", 32'(stall), 32'h0);
    chk("rstw_rd_wb", rd_wb, 32'h0);
    step(1'b1, 5'b00000, 32'd0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 5'b00000, 32'd0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 5'b00000, 32'd0, 32'h0, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFF);
    chk("late_ack_req", 32'(dmem_req), 32'h0);
    step(1'b1, 5'b00000, 32'd0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    chk("late_ack_ctrl", 32'(ctrl_wb), 32'h0);
    chk("late_ack_data", wb_data, 32'h0);

    nst = 0;
`ifdef MEM_TIMEOUT_EN
    // Load never acked: abort after TMO stall cycles
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 5'b10101, 32'd13, 32'h400, 32'h0, 32'h0, 1'b0, 32'h0);
      nst += int'(stall);
    end
    chk("tmo_req_drop", 32'(dmem_req), 32'h0);
    chk("tmo_stall_cycles", 32'(nst), 32'd4);
    step(1'b1, 5'b00000, 32'd0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h1111_1111);
    chk("tmo_err", 32'(mem_err), 32'h1);
    chk("tmo_reg_write", 32'(ctrl_wb[2]), 32'h0);
    chk("tmo_data", wb_data, 32'h0);
`else
    // Long wait: no abort without the timeout feature
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 5'b10101, 32'd13, 32'h400, 32'h0, 32'h0, 1'b0, 32'h0);
      nst += int'(stall);
    end
    step(1'b1, 5'b10101, 32'd13, 32'h400, 32'h0, 32'h0, 1'b1, 32'h7777_0001);
    nst += int'(stall);
    chk("long_stall_cycles", 32'(nst), 32'd20);
    step(1'b1, 5'b00000, 32'd0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    chk("long_wb_data", wb_data, 32'h7777_0001);
    chk("long_err", 32'(mem_err), 32'h0);
`endif
    step(1'b1, 5'b00000, 32'd0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 5'b00000, 32'd0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage; sits directly downstream of the execute stage and consumes its EX/MEM outputs (control, destination, ALU result, store data, PC+4).
- Performs word loads/stores over a req/ack data-memory handshake and stalls upstream while an access is outstanding.
- Registers the MEM/WB pipeline state (write-back control, destination, selected write-back data).

Parameters:
TIMEOUT_CYCLES, 16, max WAIT cycles before an access is aborted (used only with MEM_TIMEOUT_EN)
ALIGN_CHECK, 1, 1 = misaligned addresses are suppressed and flagged; 0 = address passed through unchecked

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
ctrl_mem  input  5  [4] mem_read, [3] mem_write, [2] reg_write, [1:0] wb_sel (00 ALU, 01 load data, 10 PC+4, 11 ALU)
rd_mem  input  32  destination register field
alu_result  input  32  ALU result / memory address
write_data1  input  32  store data
pc4_mem  input  32  PC+4
stall  output  1  upstream must hold EX/MEM inputs stable while high
dmem_req  output  1  memory request
dmem_we  output  1  1 = write, 0 = read; valid with dmem_req
dmem_addr  output  32  = alu_result
dmem_wdata  output  32  = write_data1
dmem_rdata  input  32  read data; valid with dmem_ack
dmem_ack  input  1  access complete (may arrive in the same cycle as req)
ctrl_wb  output  3  {reg_write, wb_sel} to write-back
rd_wb  output  32  registered destination
wb_data  output  32  registered write-back data
mem_err  output  1  registered one-cycle error pulse

Behaviour:
- access = mem_read | mem_write. Both bits set: treated as a write, no error.
- misaligned = ALIGN_CHECK && access && alu_result[1:0] != 0. No request is issued; the instruction completes in 1 cycle with reg_write forced to 0 in MEM/WB; mem_err pulses the next cycle.
- FSM states: IDLE, WAIT.
  - IDLE: with a valid (aligned) access, dmem_req = 1 combinationally. If dmem_ack is high in the same cycle, the access completes with no stall and the state stays IDLE. Otherwise stall = 1 and the state goes to WAIT.
  - WAIT: dmem_req = 1 and stall = 1 until dmem_ack. On ack, stall = 0 that cycle and the state goes to IDLE.
  - dmem_we and dmem_addr are combinational from the held inputs.
- dmem_ack outside an outstanding request: ignored.
- MEM/WB register updates on every clk edge:
  - stall low: ctrl_wb <= ctrl_mem[2:0]; rd_wb <= rd_mem; wb_data <= selected by wb_sel, where load data = dmem_rdata sampled in the ack cycle.
  - stall high: bubble inserted; ctrl_wb[2] <= 0 and the other fields hold, so no duplicate write-back occurs.
- Non-memory instructions (access = 0) pass through with 1-cycle latency and no stall.
- Load-to-WB latency: 1 cycle after ack.
- Reset (async, any state, including mid-access): state returns to IDLE; ctrl_wb, rd_wb, wb_data and mem_err go to 0. dmem_req and stall are forced to 0 while reset_n is low. An access interrupted by reset is dropped; a late ack is ignored.

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - A WAIT counter clears on WAIT entry.
  - If no ack has arrived by the cycle the count reaches TIMEOUT_CYCLES-1: that cycle dmem_req = 0, stall = 0 and the state returns to IDLE.
  - MEM/WB captures a bubble (reg_write = 0, wb_data = 0) and mem_err pulses the next cycle.
  - An ack arriving after the abort is ignored.
- Undefined: WAIT persists indefinitely; mem_err is raised only for misalignment; no counter logic.

Test Plan:
- ALU op, ctrl_mem=5'b00100, alu_result=0x0000_0011 -> next cycle ctrl_wb=3'b100, wb_data=0x11, stall never high, dmem_req never high.
- Load ctrl_mem=5'b10101, addr 0x100, ack after 3 cycles with rdata 0xDEAD_BEEF -> stall high 3 cycles then low, dmem_we=0 throughout, wb_data=0xDEADBEEF one cycle after ack, ctrl_wb[2]=0 during the stall cycles.
- Store ctrl_mem=5'b01000, addr 0x204, wdata 0x1234_5678, ack in the same cycle -> dmem_req=1 and dmem_we=1 for 1 cycle, no stall, ctrl_wb=3'b000.
- Misaligned load addr 0x103 -> dmem_req stays 0, mem_err=1 for 1 cycle, ctrl_wb[2]=0.
- reset_n low during WAIT of a load -> dmem_req and stall drop immediately, all outputs 0; ack 2 cycles after release has no effect.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4: load never acked -> stall high 4 cycles then released, mem_err pulse, ctrl_wb[2]=0, state IDLE.
